// File: rtl/fragment_hazard_guard.sv
// Issue controller for the read-blend-write fragment pipeline: holds back fragments whose
// framebuffer index matches an in-flight writer, caps in-flight count, retires in order.
module fragment_hazard_guard #(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int PAYLOAD_WIDTH           = 96,
  parameter int MAX_IN_FLIGHT           = 8
) (
  input  logic                               aclk,
  input  logic                               reset,
  input  logic                               hazardEnable,
  input  logic                               s_frag_tvalid,
  output logic                               s_frag_tready,
  input  logic                               s_frag_tlast,
  input  logic                               s_frag_tkeep,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex,
  input  logic [PAYLOAD_WIDTH-1:0]           s_frag_tpayload,
  output logic                               m_frag_tvalid,
  input  logic                               m_frag_tready,
  output logic                               m_frag_tlast,
  output logic                               m_frag_tkeep,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex,
  output logic [PAYLOAD_WIDTH-1:0]           m_frag_tpayload,
  input  logic                               fragmentProcessed,
  output logic [$clog2(MAX_IN_FLIGHT):0]     inFlight,
  output logic                               hazardStall,
  output logic                               retireUnderflow
);

  localparam int PTR_W = $clog2(MAX_IN_FLIGHT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_IN_FLIGHT);

  logic [MAX_IN_FLIGHT-1:0]           entry_valid;
  logic [MAX_IN_FLIGHT-1:0]           entry_keep;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] entry_index [MAX_IN_FLIGHT];
  logic [PTR_W-1:0]                   wr_ptr;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [CNT_W-1:0]                   in_flight;

  logic index_match;
  logic hazard;
  logic full;
  logic slot_free;
  logic push;
  logic pop;

  // Only registered tracker state is examined, so a same-cycle retire never unblocks.
  always_comb begin
    index_match = 1'b0;
    for (int i = 0; i < MAX_IN_FLIGHT; i++) begin
      if (entry_valid[i] && entry_keep[i] && (entry_index[i] == s_frag_tindex)) begin
        index_match = 1'b1;
      end
    end
  end

  assign hazard        = hazardEnable && s_frag_tkeep && index_match;
  assign full          = (in_flight == DEPTH);
  assign slot_free     = !m_frag_tvalid || m_frag_tready;
  assign s_frag_tready = slot_free && !full && !hazard;
  assign hazardStall   = s_frag_tvalid && hazard;
  assign push          = s_frag_tvalid && s_frag_tready;
  assign pop           = fragmentProcessed && (in_flight != '0);
  assign inFlight      = in_flight;

  always_ff @(posedge aclk) begin
    if (reset) begin
      entry_valid     <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      in_flight       <= '0;
      retireUnderflow <= 1'b0;
    end else begin
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      // Push and pop never target the same slot: push needs !full, pop needs !empty.
      if (push) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
      if (fragmentProcessed && (in_flight == '0)) begin
        retireUnderflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      entry_keep[wr_ptr]  <= s_frag_tkeep;
      entry_index[wr_ptr] <= s_frag_tindex;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      m_frag_tvalid   <= 1'b0;
      m_frag_tlast    <= 1'b0;
      m_frag_tkeep    <= 1'b0;
      m_frag_tindex   <= '0;
      m_frag_tpayload <= '0;
    end else if (push) begin
      m_frag_tvalid   <= 1'b1;
      m_frag_tlast    <= s_frag_tlast;
      m_frag_tkeep    <= s_frag_tkeep;
      m_frag_tindex   <= s_frag_tindex;
      m_frag_tpayload <= s_frag_tpayload;
    end else if (m_frag_tready) begin
      m_frag_tvalid   <= 1'b0;
    end
  end

endmodule
